// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared definitions for the load/store controller.
//   - DATA_W       : data path width (fixed at 32, four byte lanes)
//   - SZ_*         : request size encodings
//   - state_e      : controller FSM states
//   - is_misaligned: alignment check for a size / low address pair
package lsu_ctrl_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Size 3 has no defined width, so it is rejected like any misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic res;
    case (size)
      SZ_BYTE: res = 1'b0;
      SZ_HALF: res = addr_lo[0];
      SZ_WORD: res = (addr_lo != 2'b00);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational byte-lane logic for the load/store controller.
//   size_i     : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   addr_lo_i  : byte offset within the word (addr[1:0])
//   unsigned_i : 1 = zero-extend loads, 0 = sign-extend
//   word_i     : full memory word
//   wdata_i    : right-justified sub-word store data
//   load_o     : selected lane, extended to 32 bits
//   merge_o    : word_i with the store data inserted at the selected lane
module lsu_lane
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        addr_lo_i,
  input  logic              unsigned_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic [15:0]       wdata_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load path: little-endian lane select, then extension.
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    case (size_i)
      SZ_BYTE: load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: load_o = word_i;
    endcase
  end

  // Store path: overwrite only the addressed lane(s), keep the rest.
  always_comb begin
    merge_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        case (addr_lo_i)
          2'd0:    merge_o[7:0]   = wdata_i[7:0];
          2'd1:    merge_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_o[23:16] = wdata_i[7:0];
          default: merge_o[31:24] = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_lo_i[1]) merge_o[31:16] = wdata_i;
        else              merge_o[15:0]  = wdata_i;
      end
      default: merge_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator between the core memory stage and a
// word-addressed data memory (combinational read, write on posedge).
//   clock, reset_n            : clock, synchronous active-low reset
//   req_valid / req_ready     : request handshake (ready only in IDLE)
//   req_write, req_size,
//   req_unsigned, req_addr,
//   req_wdata                 : request fields, latched on accept
//   resp_valid, resp_rdata,
//   resp_misaligned           : one-cycle completion pulse and result
//   mem_addr, mem_wdata,
//   mem_we, mem_rdata         : data memory interface
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misaligned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e state_q, state_d;

  // Latched request fields. Only the low halfword of store data is kept:
  // full-word stores load mem_wdata directly on the accept edge.
  logic        write_q,    write_d;
  logic [1:0]  size_q,     size_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  addr_lo_q,  addr_lo_d;
  logic [15:0] wdata_q,    wdata_d;

  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_mis_q,   resp_mis_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
  logic              mem_we_q,     mem_we_d;

  logic              accept;
  logic              req_mis;
  logic [DATA_W-1:0] lane_load;
  logic [DATA_W-1:0] lane_merge;

  assign accept  = req_valid && (state_q == IDLE);
  assign req_mis = is_misaligned(req_size, req_addr[1:0]);

  lsu_lane u_lane (
    .size_i     (size_q),
    .addr_lo_i  (addr_lo_q),
    .unsigned_i (unsigned_q),
    .word_i     (mem_rdata),
    .wdata_i    (wdata_q),
    .load_o     (lane_load),
    .merge_o    (lane_merge)
  );

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      size_q       <= SZ_BYTE;
      unsigned_q   <= 1'b0;
      addr_lo_q    <= 2'b00;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_mis_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      addr_lo_q    <= addr_lo_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_mis_q   <= resp_mis_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_mis)                              state_d = RESP;
          else if (req_write && req_size == SZ_WORD) state_d = WRITE;
          else                                      state_d = READ;
        end
      end
      READ:    state_d = write_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the latched fields and registered outputs.
  always_comb begin
    write_d      = write_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    addr_lo_d    = addr_lo_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = '0;
    resp_mis_d   = 1'b0;
    resp_valid_d = (state_d == RESP);
    mem_we_d     = (state_d == WRITE);

    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_lo_d  = req_addr[1:0];
          wdata_d    = req_wdata[15:0];
          resp_mis_d = req_mis;
          // A misaligned request never touches the memory interface.
          if (!req_mis) begin
            mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
            if (req_write && req_size == SZ_WORD) mem_wdata_d = req_wdata;
          end
        end
      end
      READ: begin
        // mem_rdata is valid this cycle; capture the result at the edge.
        if (write_q) mem_wdata_d  = lane_merge;
        else         resp_rdata_d = lane_load;
      end
      default: ;
    endcase
  end

  // Gating with reset_n keeps a reset edge from committing a write or
  // signalling a response from the transaction being aborted.
  assign req_ready       = (state_q == IDLE);
  assign resp_valid      = resp_valid_q & reset_n;
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = resp_mis_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_we          = mem_we_q & reset_n;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_we          (mem_we),
    .mem_rdata       (mem_rdata)
  );

  always #5 clock = ~clock;

  // Data memory model: combinational read, write on posedge.
  logic [31:0] mem [0:1023];
  int          we_cnt = 0;
  logic [31:0] last_wd = '0;
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr[11:2]] <= mem_wdata;
      we_cnt  <= we_cnt + 1;
      last_wd <= mem_wdata;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one request; lat = cycles from accept edge to resp_valid (0 = timeout).
  task automatic xact(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic mis);
    @(negedge clock);
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 0; rd = '0; mis = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (resp_valid) begin
        lat = k; rd = resp_rdata; mis = resp_misaligned;
        break;
      end
      @(posedge clock); #1;
    end
    $display("xact w=%0d size=%0d uns=%0d addr=0x%08h wdata=0x%08h -> lat=%0d rdata=0x%08h mis=%0d",
             w, sz, u, a, wd, lat, rd, mis);
  endtask

  // Run a transaction and check latency, data, misaligned flag and write count.
  task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int exp_lat, input logic [31:0] exp_rd,
                     input logic exp_mis, input int exp_we);
    int lat; logic [31:0] rd; logic mis; int we0;
    we0 = we_cnt;
    xact(w, sz, u, a, wd, lat, rd, mis);
    @(negedge clock);
    check({tag, "_lat"},   lat, exp_lat);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_mis"},   {31'd0, mis}, {31'd0, exp_mis});
    check({tag, "_we"},    we_cnt - we0, exp_we);
  endtask

  initial begin
    int we0;
    int nready;
    int lat;
    int resp_seen;

    // Reset
    repeat (3) @(posedge clock);
    #1;
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_mis",   {31'd0, resp_misaligned}, 32'd0);
    check("rst_mem_addr",   mem_addr, 32'd0);
    check("rst_mem_wdata",  mem_wdata, 32'd0);
    check("rst_mem_we",     {31'd0, mem_we}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("rst_req_ready",  {31'd0, req_ready}, 32'd1);

    // Preload word 0x40 through a word store, then loads
    run("st_w40",   1, 2'd2, 0, 32'h40, 32'h8899AABB, 2, 32'h0,        0, 1);
    run("ld_b41s",  0, 2'd0, 0, 32'h41, 32'h0,        2, 32'hFFFFFFAA, 0, 0);
    run("ld_b41u",  0, 2'd0, 1, 32'h41, 32'h0,        2, 32'h000000AA, 0, 0);
    run("ld_h42s",  0, 2'd1, 0, 32'h42, 32'h0,        2, 32'hFFFF8899, 0, 0);
    run("ld_h40u",  0, 2'd1, 1, 32'h40, 32'h0,        2, 32'h0000AABB, 0, 0);
    run("ld_b40s",  0, 2'd0, 0, 32'h40, 32'h0,        2, 32'hFFFFFFBB, 0, 0);
    run("ld_w40",   0, 2'd2, 0, 32'h40, 32'h0,        2, 32'h8899AABB, 0, 0);

    // Sub-word stores (read-modify-write)
    run("st_b43",   1, 2'd0, 0, 32'h43, 32'h000000CC, 3, 32'h0,        0, 1);
    check("st_b43_wdata", last_wd, 32'hCC99AABB);
    run("rb_w40a",  0, 2'd2, 0, 32'h40, 32'h0,        2, 32'hCC99AABB, 0, 0);
    run("st_h42",   1, 2'd1, 0, 32'h42, 32'hFFFF1234, 3, 32'h0,        0, 1);
    check("st_h42_wdata", last_wd, 32'h1234AABB);
    run("ld_b43s",  0, 2'd0, 0, 32'h43, 32'h0,        2, 32'h00000012, 0, 0);
    run("st_b40",   1, 2'd0, 0, 32'h40, 32'h00000077, 3, 32'h0,        0, 1);
    run("rb_w40b",  0, 2'd2, 0, 32'h40, 32'h0,        2, 32'h1234AA77, 0, 0);

    // Misaligned requests: single-cycle response, no write
    run("mis_w42",  1, 2'd2, 0, 32'h42, 32'hDEADBEEF, 1, 32'h0,        1, 0);
    run("mis_h41",  1, 2'd1, 0, 32'h41, 32'h0000BEEF, 1, 32'h0,        1, 0);
    run("mis_s3",   0, 2'd3, 0, 32'h40, 32'h0,        1, 32'h0,        1, 0);
    run("mis_lw41", 0, 2'd2, 0, 32'h41, 32'h0,        1, 32'h0,        1, 0);
    run("rb_w40c",  0, 2'd2, 0, 32'h40, 32'h0,        2, 32'h1234AA77, 0, 0);

    // Reset during READ of a halfword store
    we0 = we_cnt;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h0000FFFF;
    @(posedge clock); #1;
    req_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort_mem_we",     {31'd0, mem_we}, 32'd0);
    check("abort_mem_addr",   mem_addr, 32'd0);
    check("abort_mem_wdata",  mem_wdata, 32'd0);
    check("abort_resp_rdata", resp_rdata, 32'd0);
    check("abort_req_ready",  {31'd0, req_ready}, 32'd1);
    reset_n = 1'b1;
    resp_seen = 0;
    repeat (4) begin
      @(posedge clock); #1;
      if (resp_valid) resp_seen++;
    end
    check("abort_no_resp", resp_seen, 0);
    check("abort_no_we",   we_cnt - we0, 0);
    $display("abort halfword store at 0x40: resp_seen=%0d writes=%0d", resp_seen, we_cnt - we0);
    run("rb_w40d",  0, 2'd2, 0, 32'h40, 32'h0,        2, 32'h1234AA77, 0, 0);

    // Back-to-back word stores with req_valid held high
    we0 = we_cnt;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h11111111;
    @(posedge clock); #1;
    req_addr = 32'h14; req_wdata = 32'h22222222;
    nready = 0;
    for (int k = 0; k < 10; k++) begin
      if (req_ready) break;
      nready++;
      @(posedge clock); #1;
    end
    check("b2b_ready_low_cycles", nready, 2);
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      if (resp_valid) begin lat = k; break; end
      @(posedge clock); #1;
    end
    check("b2b_second_lat", lat, 2);
    @(negedge clock);
    check("b2b_we_count", we_cnt - we0, 2);
    $display("back-to-back stores 0x10/0x14: ready_low=%0d second_lat=%0d writes=%0d",
             nready, lat, we_cnt - we0);
    run("rb_w10",   0, 2'd2, 0, 32'h10, 32'h0,        2, 32'h11111111, 0, 0);
    run("rb_w14",   0, 2'd2, 0, 32'h14, 32'h0,        2, 32'h22222222, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator between the single-cycle core's memory stage and the word-addressed data memory.
- The data memory has a combinational read, a write on the clock edge, and a word index taken from addr[11:2].
- The block accepts byte, halfword and word loads and stores from the core. It turns them into word-granular memory accesses, using read-modify-write for sub-word stores.
- It returns sign- or zero-extended load data and flags misaligned requests.

Parameters:
- ADDR_W, 32, width of request and memory address buses.
- DATA_W, 32, data width; fixed at 32, all byte-lane rules below assume 4 lanes.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset_n  input  1  synchronous active-low reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as misaligned.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  DATA_W  extended load data; 0 for stores and misaligned requests.
- resp_misaligned  output  1  valid with resp_valid; 1 means no memory access was made.
- mem_addr  output  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}.
- mem_wdata  output  DATA_W  full word to write.
- mem_we  output  1  write enable; memory writes on the posedge where it is high.
- mem_rdata  input  DATA_W  combinational read data for mem_addr.

Behaviour:
- Reset (reset_n=0 at a posedge): state goes to IDLE. All registered outputs clear: resp_valid=0, resp_rdata=0, resp_misaligned=0, mem_addr=0, mem_wdata=0, mem_we=0. req_ready=1 after reset.
- Reset mid-operation aborts the transaction. No write is issued on the reset edge, and no response is produced.
- Request capture: on the req_valid & req_ready edge, latch write, size, unsigned, addr and wdata. Inputs are ignored in every other state.
- Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0, 3 selects bits 31:24.
- Halfword lane: addr[1]=0 selects bits 15:0, addr[1]=1 selects bits 31:16.
- Misaligned condition: halfword with addr[0]=1, word with addr[1:0]!=0, or size 3.
- States are IDLE, READ, WRITE, RESP.
- IDLE -> RESP on accepting a misaligned request; resp_misaligned=1.
- IDLE -> WRITE on accepting an aligned word store; mem_wdata = wdata.
- IDLE -> READ on accepting any aligned load or sub-word store.
- READ: drives mem_addr and samples mem_rdata into a buffer at the end of the cycle.
- READ -> RESP for a load. Extract the lane, then sign- or zero-extend it.
- READ -> WRITE for a sub-word store. Merge wdata[7:0] or wdata[15:0] into the buffered word at the selected lane; other lanes are preserved.
- WRITE: mem_we=1 for exactly this one cycle, with mem_addr and mem_wdata stable; then -> RESP.
- RESP: resp_valid=1 for one cycle, then -> IDLE. There is no backpressure on responses.
- Cycle counts from the accept edge to resp_valid high:
  - misaligned: 1
  - word store: 2
  - load: 2
  - sub-word store: 3
- mem_we is never high outside WRITE, and never high for a misaligned request.
- Address wrap: mem_addr is derived only from the latched address; there is no increment, so no overflow case exists.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - state encodings IDLE/READ/WRITE/RESP;
  - DATA_W=32.
- One sub-module, lsu_lane: purely combinational. It provides load extract/extend and store merge given size, addr[1:0] and unsigned. The FSM lives in lsu_ctrl.

Test Plan:
- Memory word 0x40 = 0x8899AABB; byte load from 0x41, signed -> resp_rdata 0xFFFFFFAA two cycles after accept. Unsigned -> 0x000000AA.
- Halfword load from 0x42, signed, same word -> 0xFFFF8899. Word load from 0x40 -> 0x8899AABB. No mem_we at any point.
- Byte store 0x000000CC to 0x43 over 0x8899AABB -> a single mem_we cycle with mem_wdata 0xCC99AABB. resp_valid 3 cycles after accept; a readback gives 0xCC99AABB.
- Word store to 0x42 -> resp_valid with resp_misaligned=1 one cycle after accept. mem_we stays 0 and memory is unchanged. The same holds for a halfword at 0x41 and for size 3.
- reset_n=0 in READ of a halfword store -> no mem_we, no resp_valid, outputs zero, req_ready=1 the next cycle. A new request then completes normally.
- Back-to-back: req_valid held high across word stores to 0x10 and 0x14 -> the second is accepted only after RESP returns to IDLE. Exactly 2 mem_we pulses; req_ready=0 throughout the first transaction.
